// File: rtl/stereo_voice_mixer.sv
// Serial stereo mixer: captures NUM_VOICES samples per codec frame, accumulates
// one voice per cycle into L/R with per-voice pan, then attenuates and saturates.
module stereo_voice_mixer #(
  parameter int NUM_VOICES = 10,
  parameter int TIMEOUT    = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      new_frame,
  output logic                      generate_next,
  input  logic                      voices_ready,
  input  logic [16*NUM_VOICES-1:0]  voice_samples,
  input  logic [2*NUM_VOICES-1:0]   pan,
  input  logic [2:0]                atten,
  input  logic                      mute,
  output logic signed [15:0]        sample_left,
  output logic signed [15:0]        sample_right,
  output logic                      mix_valid,
  output logic                      overrun,
  output logic                      timeout
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, ACCUM, OUT} state_t;

  state_t                     state, state_nxt;
  logic [IW-1:0]              idx;
  logic [CW-1:0]              wait_cnt;
  logic [16*NUM_VOICES-1:0]   cap_samples;
  logic [2*NUM_VOICES-1:0]    cap_pan;
  logic signed [20:0]         acc_l, acc_r, acc_l_nxt, acc_r_nxt;
  logic signed [15:0]         cur;
  logic [1:0]                 cur_pan;
  logic signed [20:0]         cur_ext, cur_half, add_l, add_r;
  logic                       last_voice, wait_done;

  function automatic logic signed [15:0] scale_sat(input logic signed [20:0] a,
                                                   input logic [2:0] sh);
    logic signed [20:0] s;
    s = a >>> sh;
    if (s > 21'sd32767)
      return 16'sh7fff;
    else if (s < -21'sd32768)
      return 16'sh8000;
    else
      return s[15:0];
  endfunction

  assign last_voice    = (idx == IW'(NUM_VOICES - 1));
  assign wait_done     = (wait_cnt == CW'(TIMEOUT - 1));
  assign generate_next = (state == REQ);
  assign mix_valid     = (state == OUT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (new_frame) state_nxt = REQ;
      REQ:     if (voices_ready) state_nxt = ACCUM;
               else if (wait_done) state_nxt = IDLE;
      ACCUM:   if (last_voice) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cur      = cap_samples[16*idx +: 16];
    cur_pan  = cap_pan[2*idx +: 2];
    cur_ext  = 21'(cur);
    cur_half = cur_ext >>> 1;
    add_l    = '0;
    add_r    = '0;
    case (cur_pan)
      2'd0: begin add_l = cur_half; add_r = cur_half; end
      2'd1: add_l = cur_ext;
      2'd2: add_r = cur_ext;
      default: begin add_l = cur_ext; add_r = cur_ext; end
    endcase
    acc_l_nxt = acc_l + add_l;
    acc_r_nxt = acc_r + add_r;
  end

  // Final voice is folded straight into shift/saturate so the output register
  // and mix_valid (state OUT) line up in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      wait_cnt     <= '0;
      cap_samples  <= '0;
      cap_pan      <= '0;
      acc_l        <= '0;
      acc_r        <= '0;
      sample_left  <= '0;
      sample_right <= '0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (new_frame && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: wait_cnt <= '0;
        REQ: begin
          if (voices_ready) begin
            cap_samples <= voice_samples;
            cap_pan     <= pan;
            acc_l       <= '0;
            acc_r       <= '0;
            idx         <= '0;
          end else if (wait_done) begin
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ACCUM: begin
          acc_l <= acc_l_nxt;
          acc_r <= acc_r_nxt;
          idx   <= idx + 1'b1;
          if (last_voice) begin
            sample_left  <= mute ? '0 : scale_sat(acc_l_nxt, atten);
            sample_right <= mute ? '0 : scale_sat(acc_r_nxt, atten);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stereo_voice_mixer.sv
// Self-checking bench for stereo_voice_mixer: directed table, random mixes
// against an arithmetic reference, and hand-written flag/reset sequences.
module tb_stereo_voice_mixer;

  localparam int NV = 10;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                new_frame = 1'b0;
  logic                generate_next;
  logic                voices_ready = 1'b0;
  logic [16*NV-1:0]    voice_samples = '0;
  logic [2*NV-1:0]     pan = '0;
  logic [2:0]          atten = '0;
  logic                mute = 1'b0;
  logic signed [15:0]  sample_left, sample_right;
  logic                mix_valid, overrun, timeout;

  int total = 0;
  int bad = 0;
  int last_l = 0;
  int last_r = 0;

  stereo_voice_mixer #(.NUM_VOICES(NV), .TIMEOUT(256)) dut (
    .clk(clk), .reset(reset), .new_frame(new_frame), .generate_next(generate_next),
    .voices_ready(voices_ready), .voice_samples(voice_samples), .pan(pan),
    .atten(atten), .mute(mute), .sample_left(sample_left), .sample_right(sample_right),
    .mix_valid(mix_valid), .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [16*NV-1:0] vs;
    logic [2*NV-1:0]  pv;
    logic [2:0]       at;
    logic             m;
    int               exp_l;
    int               exp_r;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [16*NV-1:0] all_samples(input int val);
    logic [16*NV-1:0] v;
    for (int i = 0; i < NV; i++) v[16*i +: 16] = 16'(val);
    return v;
  endfunction

  function automatic logic [2*NV-1:0] all_pan(input int p);
    logic [2*NV-1:0] v;
    for (int i = 0; i < NV; i++) v[2*i +: 2] = 2'(p);
    return v;
  endfunction

  // Reference: plain integer sum per channel, floor-halve for center, shift, clamp.
  function automatic void model(input logic [16*NV-1:0] vs, input logic [2*NV-1:0] pv,
                                input int at, input bit m, output int l, output int r);
    l = 0;
    r = 0;
    for (int i = 0; i < NV; i++) begin
      int s;
      s = int'($signed(vs[16*i +: 16]));
      case (pv[2*i +: 2])
        2'd0: begin l += s >>> 1; r += s >>> 1; end
        2'd1: l += s;
        2'd2: r += s;
        default: begin l += s; r += s; end
      endcase
    end
    l = l >>> at;
    r = r >>> at;
    if (l > 32767) l = 32767;
    if (l < -32768) l = -32768;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (m) begin l = 0; r = 0; end
  endfunction

  // One full frame; nf_at > 0 pulses new_frame in cycle R+nf_at.
  task automatic do_mix(input string name, input logic [16*NV-1:0] vs,
                        input logic [2*NV-1:0] pv, input logic [2:0] at, input logic m,
                        input int nf_at, input int exp_l, input int exp_r);
    int first, pulses, gens, got_l, got_r, k;
    first = -1; pulses = 0; gens = 0; got_l = 0; got_r = 0;
    @(posedge clk); #1;
    new_frame = 1'b1; atten = at; mute = m;
    @(posedge clk); #1;
    new_frame = 1'b0;
    check({name, " gen_rise"}, int'(generate_next), 1);
    k = $urandom_range(0, 3);
    repeat (k) begin @(posedge clk); #1; end
    voice_samples = vs; pan = pv; voices_ready = 1'b1;
    @(posedge clk); #1;
    voices_ready = 1'b0;
    voice_samples = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    pan = 20'($urandom);
    for (int n = 1; n <= 20; n++) begin
      new_frame = (n == nf_at);
      if (generate_next) gens++;
      if (mix_valid) begin
        pulses++;
        if (first < 0) begin
          first = n;
          got_l = int'(sample_left);
          got_r = int'(sample_right);
        end
      end
      @(posedge clk); #1;
    end
    new_frame = 1'b0;
    mute = 1'b0;
    check({name, " latency"}, first, 11);
    check({name, " pulses"}, pulses, 1);
    check({name, " gen_after"}, gens, 0);
    check({name, " left"}, got_l, exp_l);
    check({name, " right"}, got_r, exp_r);
    last_l = exp_l;
    last_r = exp_r;
  endtask

  task automatic check_reset_state(input string name);
    check({name, " L"}, int'(sample_left), 0);
    check({name, " R"}, int'(sample_right), 0);
    check({name, " mv"}, int'(mix_valid), 0);
    check({name, " gen"}, int'(generate_next), 0);
    check({name, " ovr"}, int'(overrun), 0);
    check({name, " tmo"}, int'(timeout), 0);
  endtask

  vec_t tbl[9];

  initial begin
    int el, er, gens, mvs;
    logic [16*NV-1:0] vs;
    logic [2*NV-1:0]  pv;
    logic [2:0]       at;
    logic             m;

    tbl[0] = '{"center1000", all_samples(1000), all_pan(0), 3'd0, 1'b0, 5000, 5000};
    vs = '0; vs[15:0] = 16'sh7fff; vs[31:16] = 16'sh7fff;
    tbl[1] = '{"satpos", vs, 20'h00005, 3'd0, 1'b0, 32767, 0};
    vs = '0; vs[15:0] = 16'sh8000; vs[31:16] = 16'sh8000;
    tbl[2] = '{"satneg", vs, 20'h00005, 3'd0, 1'b0, -32768, 0};
    tbl[3] = '{"both20000", all_samples(20000), all_pan(3), 3'd3, 1'b0, 25000, 25000};
    tbl[4] = '{"mute", all_samples(1000), all_pan(0), 3'd0, 1'b1, 0, 0};
    tbl[5] = '{"halfneg", all_samples(-3), all_pan(0), 3'd0, 1'b0, -20, -20};
    vs = '0; vs[15:0] = 16'(-1000);
    tbl[6] = '{"rightonly", vs, 20'h00002, 3'd0, 1'b0, 0, -1000};
    tbl[7] = '{"att7pos", all_samples(32767), all_pan(3), 3'd7, 1'b0, 2559, 2559};
    tbl[8] = '{"att7neg", all_samples(-32768), all_pan(3), 3'd7, 1'b0, -2560, -2560};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_state("reset");

    foreach (tbl[i])
      do_mix(tbl[i].name, tbl[i].vs, tbl[i].pv, tbl[i].at, tbl[i].m, 0,
             tbl[i].exp_l, tbl[i].exp_r);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < NV; i++) vs[16*i +: 16] = 16'($urandom);
      pv = 20'($urandom);
      at = 3'($urandom_range(0, 7));
      m  = ($urandom_range(0, 7) == 0);
      model(vs, pv, int'(at), m, el, er);
      do_mix("random", vs, pv, at, m, 0, el, er);
    end

    // Stray voices_ready in IDLE must do nothing.
    gens = 0; mvs = 0;
    voices_ready = 1'b1;
    @(posedge clk); #1 voices_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      if (generate_next) gens++;
      if (mix_valid) mvs++;
      @(posedge clk); #1;
    end
    check("idle_ready gen", gens, 0);
    check("idle_ready mv", mvs, 0);
    check("idle_ready ovr", int'(overrun), 0);
    check("idle_ready L", int'(sample_left), last_l);

    // new_frame coinciding with OUT is dropped and flagged.
    do_mix("ovr_out", all_samples(1000), all_pan(0), 3'd0, 1'b0, 11, 5000, 5000);
    check("ovr_out flag", int'(overrun), 1);

    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check_reset_state("reset2");

    do_mix("ovr_accum", all_samples(20000), all_pan(3), 3'd3, 1'b0, 3, 25000, 25000);
    check("ovr_accum flag", int'(overrun), 1);

    // No voices_ready: generate_next held for the full wait window, then abandon.
    @(posedge clk); #1 new_frame = 1'b1;
    @(posedge clk); #1 new_frame = 1'b0;
    gens = 0; mvs = 0;
    for (int n = 0; n < 300; n++) begin
      if (generate_next) gens++;
      if (mix_valid) mvs++;
      @(posedge clk); #1;
    end
    check("timeout gen_cycles", gens, 256);
    check("timeout mv", mvs, 0);
    check("timeout flag", int'(timeout), 1);
    check("timeout hold L", int'(sample_left), last_l);
    check("timeout hold R", int'(sample_right), last_r);

    // Reset two cycles into ACCUM.
    @(posedge clk); #1 new_frame = 1'b1;
    @(posedge clk); #1 new_frame = 1'b0;
    voice_samples = all_samples(1000); pan = all_pan(0); voices_ready = 1'b1;
    @(posedge clk); #1 voices_ready = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check_reset_state("midreset");
    mvs = 0;
    for (int n = 0; n < 15; n++) begin
      if (mix_valid) mvs++;
      @(posedge clk); #1;
    end
    check("midreset mv", mvs, 0);
    do_mix("after_reset", all_samples(1000), all_pan(0), 3'd0, 1'b0, 0, 5000, 5000);
    do_mix("mute_end", all_samples(-7), all_pan(1), 3'd0, 1'b1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stereo_voice_mixer.md
Name: stereo_voice_mixer

Overview:
- Sits between music_player and the ac97_if codec interface in the lab5 audio path.
- On each codec frame request (new_frame), it requests a fresh set of per-voice samples, then sums them serially into left and right channels using a per-voice pan code, a master attenuation and saturation.
- Drives PCM_Playback_Left/Right and a new-sample strobe for wave_display_top.

Parameters:
- NUM_VOICES, 10, number of 16-bit signed voice samples mixed per frame (1..16).
- TIMEOUT, 256, cycles to wait for voices_ready before abandoning a frame.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- new_frame  input  1  one-cycle pulse from codec (PCM_Playback_Accept); starts a mix.
- generate_next  output  1  level request to music_player for the next voice samples.
- voices_ready  input  1  one-cycle pulse; voice_samples valid this cycle.
- voice_samples  input  16*NUM_VOICES  packed signed samples; voice i at [16i+15:16i].
- pan  input  2*NUM_VOICES  per-voice pan code; voice i at [2i+1:2i].
- atten  input  3  master attenuation, arithmetic right shift 0..7.
- mute  input  1  forces output samples to zero.
- sample_left  output  16  registered signed left sample.
- sample_right  output  16  registered signed right sample.
- mix_valid  output  1  one-cycle pulse when sample_left/right update.
- overrun  output  1  sticky; set when new_frame arrives while not IDLE.
- timeout  output  1  sticky; set when voices_ready is not seen within TIMEOUT cycles.

Behaviour:
- Reset: state IDLE; sample_left/right=0; mix_valid=0; generate_next=0; overrun=0; timeout=0; accumulators=0; index=0.
- States: IDLE, REQ, ACCUM, OUT.
- IDLE: on new_frame go to REQ. generate_next rises the next cycle.
- REQ: generate_next=1 and the wait counter increments each cycle.
  - On voices_ready, capture all voice_samples and pan into an internal register, clear the accumulators, set index=0, go to ACCUM, and drop generate_next the next cycle.
  - If the counter reaches TIMEOUT-1 without voices_ready, set timeout, go to IDLE, and leave the outputs holding their previous values.
- ACCUM: one voice per cycle from the captured copy, index 0..NUM_VOICES-1. Accumulators are 21-bit signed; the 16-bit sample is sign-extended.
  - pan 0 (center): add sample>>>1 to L and R.
  - pan 1: add sample to L only.
  - pan 2: add sample to R only.
  - pan 3: add full sample to both.
  - After index NUM_VOICES-1, go to OUT.
- OUT (one cycle):
  - Each accumulator is arithmetic-shifted right by atten, then saturated to [-32768, 32767].
  - The result is registered into sample_left/right; 0 if mute is sampled high this cycle.
  - mix_valid=1 for exactly this cycle, then return to IDLE.
- Latency: voices_ready in cycle R gives mix_valid in cycle R+NUM_VOICES+1 (R+11 by default).
- new_frame in any state other than IDLE: set overrun, ignore the frame, do not disturb the mix in progress.
- voices_ready outside REQ: ignored, no flag.
- voice_samples and pan may change after voices_ready without affecting the mix in progress.
- new_frame and the return to IDLE in the same cycle (OUT state): counts as overrun and is dropped.
- Flags clear only on reset.
- Reset asserted mid-operation: next cycle matches the reset values, including generate_next=0 and no mix_valid.

Test Plan:
- Center pan, all ten voices at 1000, atten=0, pan=0 -> mix_valid 11 cycles after voices_ready; L=R=5000.
- Voice0 at 32767 pan 1, voice1 at 32767 pan 1, others 0 -> L=32767 (saturated), R=0. Same with -32768 -> L=-32768.
- All voices 20000 pan 3, atten=3 -> sum 200000>>>3=25000; L=R=25000, no saturation.
- new_frame pulsed during ACCUM -> overrun=1; the current mix completes with correct values; exactly one mix_valid.
- No voices_ready after new_frame -> generate_next high for 256 cycles, then low; timeout=1; sample_left/right keep their previous values; no mix_valid.
- Reset asserted two cycles into ACCUM -> next cycle all outputs 0, state IDLE; a following new_frame/voices_ready gives a correct mix. mute=1 at OUT -> L=R=0 with mix_valid=1.
